// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings and the parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Parity over the low nbits of data; odd mode inverts the even result.
    function automatic logic parity_bit(input logic [7:0] data, input int nbits, input int mode);
        logic p;
        p = (mode == PARITY_ODD);
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) begin
                p = p ^ data[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered head word; a write into an emptying FIFO bypasses memory.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == (AW+1)'(DEPTH));
    assign do_pop      = rd_en && !empty;
    // A simultaneous pop frees the slot before the push lands, so full+pop is not an overflow.
    assign do_push     = wr_en && (!full || do_pop);
    assign overflow    = wr_en && full && !do_pop;
    assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
        end else if (do_push && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wr_data;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

    assign rd_data = head_reg;
    assign valid   = !empty;

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART: runtime baud divisor, 5-8 data bits, optional parity, 1/2 stop bits,
// 16x oversampled majority-vote receiver feeding an RX FIFO with per-word error flags.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int OS_W  = $clog2(2 * OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  STOP_LAST = OS_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  MID_A     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  MID_B     = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0]  MID_C     = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic [DIV_W-1:0] div_m1;
    assign div_m1 = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);

    // ---------------- transmitter ----------------
    tx_state_t            tx_state_reg;
    logic                 tx_reg;
    logic                 tx_ready_reg;
    logic                 tx_busy_reg;
    logic [DIV_W-1:0]     tx_cnt_reg;
    logic [OS_W-1:0]      tx_os_reg;
    logic [BIT_W-1:0]     tx_bit_reg;
    logic [DATA_BITS-1:0] tx_shift_reg;
    logic                 tx_par_reg;
    logic                 tx_accept;
    logic                 tx_tick;

    assign tx_accept = tx_valid && tx_ready_reg;
    assign tx_tick   = (tx_cnt_reg == '0) && (tx_state_reg != TX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_reg       <= 1'b1;
            tx_ready_reg <= 1'b1;
            tx_busy_reg  <= 1'b0;
            tx_cnt_reg   <= div_m1;
            tx_os_reg    <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
        end else begin
            if (tx_accept || (tx_cnt_reg == '0)) begin
                tx_cnt_reg <= div_m1;
            end else begin
                tx_cnt_reg <= tx_cnt_reg - DIV_W'(1);
            end
            case (tx_state_reg)
                TX_IDLE: begin
                    if (tx_valid) begin
                        tx_state_reg <= TX_START;
                        tx_reg       <= 1'b0;
                        tx_ready_reg <= 1'b0;
                        tx_busy_reg  <= 1'b1;
                        tx_shift_reg <= tx_data;
                        tx_par_reg   <= parity_bit(8'(tx_data), DATA_BITS, PARITY);
                        tx_os_reg    <= '0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        if (tx_os_reg == OS_LAST) begin
                            tx_os_reg    <= '0;
                            tx_bit_reg   <= '0;
                            tx_state_reg <= TX_DATA;
                            tx_reg       <= tx_shift_reg[0];
                        end else begin
                            tx_os_reg <= tx_os_reg + OS_W'(1);
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        if (tx_os_reg == OS_LAST) begin
                            tx_os_reg <= '0;
                            if (tx_bit_reg == BIT_LAST) begin
                                if (PARITY != PARITY_NONE) begin
                                    tx_state_reg <= TX_PARITY;
                                    tx_reg       <= tx_par_reg;
                                end else begin
                                    tx_state_reg <= TX_STOP;
                                    tx_reg       <= 1'b1;
                                end
                            end else begin
                                tx_bit_reg   <= tx_bit_reg + BIT_W'(1);
                                tx_shift_reg <= tx_shift_reg >> 1;
                                tx_reg       <= tx_shift_reg[1];
                            end
                        end else begin
                            tx_os_reg <= tx_os_reg + OS_W'(1);
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_tick) begin
                        if (tx_os_reg == OS_LAST) begin
                            tx_os_reg    <= '0;
                            tx_state_reg <= TX_STOP;
                            tx_reg       <= 1'b1;
                        end else begin
                            tx_os_reg <= tx_os_reg + OS_W'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (tx_os_reg == STOP_LAST) begin
                            tx_os_reg    <= '0;
                            tx_state_reg <= TX_IDLE;
                            tx_ready_reg <= 1'b1;
                            tx_busy_reg  <= 1'b0;
                        end else begin
                            tx_os_reg <= tx_os_reg + OS_W'(1);
                        end
                    end
                end
                default: begin
                    tx_state_reg <= TX_IDLE;
                    tx_reg       <= 1'b1;
                    tx_ready_reg <= 1'b1;
                    tx_busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = tx_reg;
    assign tx_ready = tx_ready_reg;
    assign tx_busy  = tx_busy_reg;

    // ---------------- receiver ----------------
    rx_state_t            rx_state_reg;
    logic                 rx_meta_reg;
    logic                 rx_sync_reg;
    logic                 rx_prev_reg;
    logic [DIV_W-1:0]     rx_cnt_reg;
    logic [OS_W-1:0]      rx_os_reg;
    logic [BIT_W-1:0]     rx_bit_reg;
    logic [DATA_BITS-1:0] rx_shift_reg;
    logic                 rx_s0_reg;
    logic                 rx_s1_reg;
    logic                 rx_perr_reg;
    logic                 rx_push_reg;
    logic [DATA_BITS+1:0] rx_push_data_reg;
    logic                 start_edge;
    logic                 rx_tick;
    logic                 majority;

    assign start_edge = rx_prev_reg && !rx_sync_reg;
    assign rx_tick    = (rx_cnt_reg == '0) && (rx_state_reg != RX_IDLE) && (rx_state_reg != RX_BREAK);
    // Third sample is the live synchronised line at the last of the three mid-bit ticks.
    assign majority   = (rx_s0_reg & rx_s1_reg) | (rx_s0_reg & rx_sync_reg) | (rx_s1_reg & rx_sync_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_reg     <= RX_IDLE;
            rx_cnt_reg       <= div_m1;
            rx_os_reg        <= '0;
            rx_bit_reg       <= '0;
            rx_shift_reg     <= '0;
            rx_s0_reg        <= 1'b1;
            rx_s1_reg        <= 1'b1;
            rx_perr_reg      <= 1'b0;
            rx_push_reg      <= 1'b0;
            rx_push_data_reg <= '0;
        end else begin
            rx_push_reg <= 1'b0;
            if (((rx_state_reg == RX_IDLE) && start_edge) || (rx_cnt_reg == '0)) begin
                rx_cnt_reg <= div_m1;
            end else begin
                rx_cnt_reg <= rx_cnt_reg - DIV_W'(1);
            end
            case (rx_state_reg)
                RX_IDLE: begin
                    if (start_edge) begin
                        rx_state_reg <= RX_START;
                        rx_os_reg    <= '0;
                        rx_perr_reg  <= 1'b0;
                    end
                end
                RX_BREAK: begin
                    if (rx_sync_reg) begin
                        rx_state_reg <= RX_IDLE;
                    end
                end
                default: begin
                    if (rx_tick) begin
                        rx_os_reg <= (rx_os_reg == OS_LAST) ? '0 : rx_os_reg + OS_W'(1);
                        if (rx_os_reg == MID_A) begin
                            rx_s0_reg <= rx_sync_reg;
                        end
                        if (rx_os_reg == MID_B) begin
                            rx_s1_reg <= rx_sync_reg;
                        end
                        if (rx_os_reg == MID_C) begin
                            case (rx_state_reg)
                                RX_START: begin
                                    if (majority) begin
                                        rx_state_reg <= RX_IDLE;
                                    end
                                end
                                RX_DATA:   rx_shift_reg <= {majority, rx_shift_reg[DATA_BITS-1:1]};
                                RX_PARITY: rx_perr_reg  <= (majority != parity_bit(8'(rx_shift_reg), DATA_BITS, PARITY));
                                RX_STOP: begin
                                    rx_push_reg      <= 1'b1;
                                    rx_push_data_reg <= {rx_perr_reg, !majority, rx_shift_reg};
                                    rx_state_reg     <= majority ? RX_IDLE : RX_BREAK;
                                end
                                default: ;
                            endcase
                        end
                        if (rx_os_reg == OS_LAST) begin
                            case (rx_state_reg)
                                RX_START: begin
                                    rx_state_reg <= RX_DATA;
                                    rx_bit_reg   <= '0;
                                end
                                RX_DATA: begin
                                    if (rx_bit_reg == BIT_LAST) begin
                                        rx_state_reg <= (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                                    end else begin
                                        rx_bit_reg <= rx_bit_reg + BIT_W'(1);
                                    end
                                end
                                RX_PARITY: rx_state_reg <= RX_STOP;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign rx_busy = (rx_state_reg != RX_IDLE);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rx_push_reg),
        .wr_data  (rx_push_data_reg),
        .rd_en    (rx_ready),
        .rd_data  ({rx_parity_err, rx_frame_err, rx_data}),
        .valid    (rx_valid),
        .overflow (rx_overrun)
    );

endmodule
